// File: rtl/ccg_tt_pkg.sv
// Shared types and MISR arithmetic for the CCG truth-table sweeper.
// misr_next is also used by the testbench reference model.
package ccg_tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    FIN   = 2'd2
  } state_e;

  localparam int          DEF_SIG_W  = 16;
  localparam logic [15:0] DEF_POLY   = 16'h1021;
  localparam int          MISR_MAX_W = 32;

  // One MISR step on a width-bit register.
  // Operands are carried in 32-bit containers; bits above width are masked off.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] data,
                                            input logic [31:0] poly,
                                            input int          width);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (width >= MISR_MAX_W) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    r = (sig << 1) ^ data;
    if (sig[5'(width - 1)]) r = r ^ poly;
    return r & mask;
  endfunction

endpackage

// File: rtl/ccg_misr.sv
// Multiple-input signature register with synchronous clear and update enable.
// The next-state value is exported so the caller can compare it before it lands.
module ccg_misr
  import ccg_tt_pkg::*;
#(
  parameter int               SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] data,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  logic [31:0] nxt_full;

  assign nxt_full = misr_next(32'(sig), 32'(data), 32'(POLY), SIG_W);
  assign sig_next = nxt_full[SIG_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/ccg_tt_sweeper.sv
// Drives every input combination into a combinational CUT, captures its
// truth table and a MISR signature, and reports whether the signature matches.
module ccg_tt_sweeper
  import ccg_tt_pkg::*;
#(
  parameter int               N_IN   = 2,
  parameter int               N_OUT  = 8,
  parameter int               SETTLE = 1,
  parameter int               SIG_W  = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [N_IN-1:0]               cut_x,
  input  logic [N_OUT-1:0]              cut_f,
  input  logic [SIG_W-1:0]              exp_sig,
  output logic                          busy,
  output logic                          done,
  output logic [(2**N_IN)*N_OUT-1:0]    tt,
  output logic [SIG_W-1:0]              sig,
  output logic                          match
);

  localparam int              TT_W     = (2**N_IN) * N_OUT;
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_V   = '1;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [N_IN-1:0]   vec_q;
  logic [TT_W-1:0]   tt_q;
  logic [SIG_W-1:0]  exp_q;
  logic              match_q;
  logic              accept;
  logic              sample;
  logic [SIG_W-1:0]  sig_next;

  assign accept = (state_q == IDLE) && start;
  assign sample = (state_q == APPLY) && (cnt_q == SETTLE_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= APPLY;
            cnt_q   <= '0;
            vec_q   <= '0;
            tt_q    <= '0;
            exp_q   <= exp_sig;
            match_q <= 1'b0;
          end
        end
        APPLY: begin
          if (sample) begin
            tt_q[int'(vec_q)*N_OUT +: N_OUT] <= cut_f;
            cnt_q <= '0;
            // Last vector: compare the signature that is landing on this edge
            // so match is already valid during the done cycle.
            if (vec_q == LAST_V) begin
              state_q <= FIN;
              match_q <= (sig_next == exp_q);
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  ccg_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .en       (sample),
    .data     (SIG_W'(cut_f)),
    .sig      (sig),
    .sig_next (sig_next)
  );

  assign cut_x = vec_q;
  assign busy  = (state_q == APPLY);
  assign done  = (state_q == FIN);
  assign tt    = tt_q;
  assign match = match_q;

endmodule

// File: tb/tb_ccg_tt_sweeper.sv
// Self-checking bench: three sweepers (SETTLE=1,3,0) driven by behavioural CUT stubs.
module tb_ccg_tt_sweeper;
  import ccg_tt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a [3];
  logic [15:0] exp_a   [3];
  logic [1:0]  cutx_w  [3];
  logic [7:0]  cutf_w  [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [31:0] tt_w    [3];
  logic [15:0] sig_w   [3];
  logic        match_w [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ccg_tt_sweeper #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .cut_x(cutx_w[0]), .cut_f(cutf_w[0]),
    .exp_sig(exp_a[0]), .busy(busy_w[0]), .done(done_w[0]), .tt(tt_w[0]), .sig(sig_w[0]),
    .match(match_w[0]));
  ccg_tt_sweeper #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .cut_x(cutx_w[1]), .cut_f(cutf_w[1]),
    .exp_sig(exp_a[1]), .busy(busy_w[1]), .done(done_w[1]), .tt(tt_w[1]), .sig(sig_w[1]),
    .match(match_w[1]));
  ccg_tt_sweeper #(.SETTLE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .cut_x(cutx_w[2]), .cut_f(cutf_w[2]),
    .exp_sig(exp_a[2]), .busy(busy_w[2]), .done(done_w[2]), .tt(tt_w[2]), .sig(sig_w[2]),
    .match(match_w[2]));

  // CUT stubs: u1 table is selectable (identity / constant / random LUT) with
  // optional garbage on cycles where cut_x has just changed; u3 sees a 3-cycle lag.
  int         mode1 = 0;
  bit         noise_en = 1'b0;
  logic [7:0] lut1 [4];
  logic [7:0] lut3 [4];
  logic [1:0] last_x1 = 2'd0;
  logic [7:0] rnd = 8'h00;
  logic [1:0] h1 = 2'd0, h2 = 2'd0, h3 = 2'd0;
  logic [7:0] base1;

  always @(posedge clk) begin
    last_x1 <= cutx_w[0];
    rnd     <= 8'($urandom);
    h1 <= cutx_w[1];
    h2 <= h1;
    h3 <= h2;
  end

  always_comb begin
    base1 = (mode1 == 0) ? {6'b0, cutx_w[0]} : (mode1 == 1) ? 8'hFF : lut1[cutx_w[0]];
    cutf_w[0] = base1 ^ ((noise_en && (!busy_w[0] || cutx_w[0] != last_x1)) ? rnd : 8'h00);
    cutf_w[1] = lut3[h3];
    cutf_w[2] = {6'b0, cutx_w[2]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: table is just the per-vector outputs concatenated; the
  // signature folds the per-vector outputs through the MISR in vector order.
  function automatic logic [31:0] model_tt(input logic [7:0] v [4]);
    return {v[3], v[2], v[1], v[0]};
  endfunction

  function automatic logic [15:0] model_sig(input logic [7:0] v [4]);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < 4; i++) s = misr_next(s, 32'(v[i]), 32'h1021, 16);
    return s[15:0];
  endfunction

  // Starts one sweep and observes 40 cycles; spam keeps start high while busy/done.
  task automatic sweep(input int d, input logic [15:0] e, input bit spam,
                       output int busy_n, output int done_n, output int lat,
                       output logic done_match);
    busy_n = 0; done_n = 0; lat = -1; done_match = 1'b0;
    @(negedge clk);
    exp_a[d] = e;
    start_a[d] = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      start_a[d] = spam && (busy_w[d] || done_w[d]);
      if (busy_w[d]) busy_n++;
      if (done_w[d]) begin
        done_n++;
        if (lat < 0) begin
          lat = k;
          done_match = match_w[d];
        end
      end
      @(negedge clk);
    end
    start_a[d] = 1'b0;
  endtask

  initial begin
    logic [7:0]  v [4];
    logic [31:0] clean_tt;
    logic [15:0] msig;
    int bn, dn, lat;
    logic dm;
    int waited;

    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      exp_a[i]   = 16'h0;
    end
    for (int i = 0; i < 4; i++) begin
      lut1[i] = 8'h00;
      lut3[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_w[0]), 64'd0);
    chk("rst_done", 64'(done_w[0]), 64'd0);
    chk("rst_tt", 64'(tt_w[0]), 64'd0);
    chk("rst_sig", 64'(sig_w[0]), 64'd0);
    chk("rst_match", 64'(match_w[0]), 64'd0);
    chk("rst_cutx", 64'(cutx_w[0]), 64'd0);
    rst_n = 1'b1;

    // Identity stub
    mode1 = 0;
    sweep(0, 16'h0003, 1'b0, bn, dn, lat, dm);
    chk("id_tt", 64'(tt_w[0]), 64'h03020100);
    chk("id_sig", 64'(sig_w[0]), 64'h0003);
    chk("id_match", 64'(match_w[0]), 64'd1);
    chk("id_match_at_done", 64'(dm), 64'd1);
    chk("id_latency", 64'(lat), 64'd9);
    chk("id_busy_cycles", 64'(bn), 64'd8);
    chk("id_done_count", 64'(dn), 64'd1);

    // Constant stub with a deliberately wrong expectation
    mode1 = 1;
    sweep(0, 16'h0504, 1'b0, bn, dn, lat, dm);
    chk("ff_tt", 64'(tt_w[0]), 64'hFFFFFFFF);
    chk("ff_sig", 64'(sig_w[0]), 64'h0505);
    chk("ff_match", 64'(match_w[0]), 64'd0);

    // Hold in IDLE
    repeat (5) @(negedge clk);
    chk("hold_tt", 64'(tt_w[0]), 64'hFFFFFFFF);
    chk("hold_sig", 64'(sig_w[0]), 64'h0505);

    // Random tables: clean run, then noisy run with start spam
    mode1 = 2;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 4; i++) begin
        lut1[i] = 8'($urandom);
        v[i] = lut1[i];
      end
      msig = model_sig(v);
      noise_en = 1'b0;
      sweep(0, msig, 1'b0, bn, dn, lat, dm);
      clean_tt = tt_w[0];
      chk("rnd_tt", 64'(tt_w[0]), 64'(model_tt(v)));
      chk("rnd_sig", 64'(sig_w[0]), 64'(msig));
      chk("rnd_match", 64'(match_w[0]), 64'd1);
      noise_en = 1'b1;
      sweep(0, msig ^ 16'h0001, 1'b1, bn, dn, lat, dm);
      noise_en = 1'b0;
      chk("noisy_tt_vs_clean", 64'(tt_w[0]), 64'(clean_tt));
      chk("noisy_sig", 64'(sig_w[0]), 64'(msig));
      chk("noisy_match", 64'(match_w[0]), 64'd0);
      chk("noisy_done_count", 64'(dn), 64'd1);
      chk("noisy_busy_cycles", 64'(bn), 64'd8);
    end

    // SETTLE=3 with a lagging CUT
    for (int i = 0; i < 4; i++) begin
      lut3[i] = 8'($urandom);
      v[i] = lut3[i];
    end
    msig = model_sig(v);
    sweep(1, msig, 1'b0, bn, dn, lat, dm);
    chk("lag_tt", 64'(tt_w[1]), 64'(model_tt(v)));
    chk("lag_sig", 64'(sig_w[1]), 64'(msig));
    chk("lag_match", 64'(match_w[1]), 64'd1);
    chk("lag_busy_cycles", 64'(bn), 64'd16);
    chk("lag_latency", 64'(lat), 64'd17);

    // SETTLE=0 identity
    sweep(2, 16'h0003, 1'b0, bn, dn, lat, dm);
    chk("s0_tt", 64'(tt_w[2]), 64'h03020100);
    chk("s0_busy_cycles", 64'(bn), 64'd4);
    chk("s0_latency", 64'(lat), 64'd5);
    chk("s0_match", 64'(match_w[2]), 64'd1);

    // Asynchronous reset during vector 2
    mode1 = 0;
    @(negedge clk);
    exp_a[0] = 16'h0003;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    waited = 0;
    while (cutx_w[0] != 2'd2 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("reach_vec2", 64'(cutx_w[0]), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_w[0]), 64'd0);
    chk("mid_rst_tt", 64'(tt_w[0]), 64'd0);
    chk("mid_rst_sig", 64'(sig_w[0]), 64'd0);
    chk("mid_rst_cutx", 64'(cutx_w[0]), 64'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_w[0]) dn++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done_w[0]) dn++;
    end
    chk("mid_rst_no_done", 64'(dn), 64'd0);
    sweep(0, 16'h0003, 1'b0, bn, dn, lat, dm);
    chk("post_rst_tt", 64'(tt_w[0]), 64'h03020100);
    chk("post_rst_sig", 64'(sig_w[0]), 64'h0003);
    chk("post_rst_match", 64'(match_w[0]), 64'd1);
    chk("post_rst_latency", 64'(lat), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccg_tt_sweeper.md
# ccg_tt_sweeper

Sequential test harness stage for the generated combinational benchmark circuits (2-input, 8-output CCG netlists). It sits directly upstream and downstream of a circuit under test. It drives every input combination in order, waits a programmable settle time, and captures each output word into a truth-table register. It also compresses the captured words into a MISR signature and compares that signature against an expected value, so the dataset flow can check netlist equivalence in simulation or on FPGA.

## Interface
Parameters:
- N_IN, 2: width of the CUT input vector; sweep length is 2**N_IN vectors.
- N_OUT, 8: width of the CUT output vector.
- SETTLE, 1: extra cycles each vector is held before sampling; legal range 0..15.
- SIG_W, 16: MISR width; must be ≥ N_OUT.
- POLY, 16'h1021: MISR feedback polynomial, SIG_W bits.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  sweep request; sampled only in IDLE.
- cut_x  out  N_IN  vector driven to the CUT inputs (x0 = bit 0).
- cut_f  in  N_OUT  CUT outputs (f1 = bit 0).
- exp_sig  in  SIG_W  expected signature; sampled on the cycle start is accepted.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse after the final sample.
- tt  out  2**N_IN*N_OUT  captured table; vector v occupies bits [v*N_OUT +: N_OUT].
- sig  out  SIG_W  MISR signature.
- match  out  1  sig == latched exp_sig; valid from done until the next start.

## Operation
- FSM states:
  - IDLE: start=1 → APPLY. On entry to APPLY: clear tt, sig and match; set cut_x=0; settle counter=0; latch exp_sig.
  - APPLY: hold cut_x. Increment the counter each cycle. When counter==SETTLE, register cut_f on that edge:
    - tt[v] ← cut_f.
    - MISR update.
    - If v == 2**N_IN-1 → FIN. Otherwise v+1, counter=0, stay in APPLY.
  - FIN: one cycle. done=1, busy=0, match ← (sig==exp_sig). Then → IDLE.
- MISR update: sig ← (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended cut_f. Seed is 0.
- cut_f is ignored on every cycle except the sampling edges.
- start while busy or in FIN is ignored. No queuing.
- tt, sig and match hold their values in IDLE until the next accepted start.
- Vector counter is N_IN bits. Its wrap after the last vector is never used; the transition to FIN is taken instead.

## Timing
- Reset values: cut_x=0, busy=0, done=0, tt=0, sig=0, match=0, state IDLE.
- busy rises on the edge that accepts start. It is high for exactly 2**N_IN*(SETTLE+1) cycles.
- Each vector is stable on cut_x for SETTLE+1 cycles. cut_x is registered and changes only on the edge after a sample.
- done is asserted in the cycle immediately after busy falls. Latency from the start edge to done is 2**N_IN*(SETTLE+1)+1 cycles. For defaults: 8 busy cycles, done in cycle 9.
- Back-to-back operation: start asserted during the done cycle is ignored. start in the following IDLE cycle is accepted.
- Reset mid-sweep forces IDLE immediately and asynchronously, with all outputs at their reset values. No partial done is produced.

## Structure
- Package ccg_tt_pkg holds:
  - the state enum {IDLE, APPLY, FIN};
  - default POLY and SIG_W constants;
  - the function misr_next(sig, data) used by both RTL and the bench model.
- One sub-module, ccg_misr: parameterised SIG_W/POLY, with clear and enable inputs. It instantiates the register and update logic.
- Top-level FSM, settle counter, vector counter and tt register live in ccg_tt_sweeper.

## Test plan
- Identity stub, cut_f={6'b0,cut_x}, SETTLE=1, exp_sig=16'h0003 → tt=32'h03020100, sig=16'h0003, match=1, done at cycle 9 after start.
- Constant stub, cut_f=8'hFF → tt=32'hFFFFFFFF, sig=16'h0505. With exp_sig=16'h0504, match=0.
- SETTLE=3 with a stub whose cut_f lags cut_x by 3 cycles → samples equal the lag-free values; busy high exactly 16 cycles.
- Toggle cut_f on non-sampling cycles and pulse start every cycle while busy → sampled table unchanged vs the clean run; exactly one done.
- Deassert rst_n during vector 2 → busy=0, tt=0, sig=0 immediately. A fresh start completes with a correct result.
- SETTLE=0 on the identity stub → busy high 4 cycles; tt=32'h03020100.
